// File: rtl/delete0_if.sv
// rtl/delete0_if.sv - serial bit input and frame RAM write port for the zero-deletion receiver
interface delete0_if #(
    parameter int ADDR_W = 9
);
    logic              bit_in;
    logic              bit_valid;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    modport master (
        output bit_in, bit_valid,
        input  ram_wren, ram_waddr, ram_wdata
    );

    modport slave (
        input  bit_in, bit_valid,
        output ram_wren, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/delete0.sv
// rtl/delete0.sv - HDLC receive: flag hunt, zero deletion, abort detect, byte assembly into frame RAM
module delete0 #(
    parameter int ADDR_W    = 9,
    parameter int MAX_BYTES = 511
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inr,
    delete0_if.slave        bus,
    output logic            frame_done,
    output logic [ADDR_W:0] frame_len,
    output logic            abort_err,
    output logic            align_err,
    output logic            ovf_err,
    output logic            in_frame
);
    typedef enum logic {HUNT, DATA} state_t;

    localparam logic [ADDR_W:0] MAX_CNT = MAX_BYTES[ADDR_W:0];

    state_t            state, state_nx;
    logic [7:0]        raw_sr, raw_nx, raw_shift;
    logic [2:0]        ones_cnt, ones_nx;
    logic [2:0]        dly_cnt, dly_nx;
    logic [6:0]        dly_sr, dly_sr_nx;
    logic [2:0]        bit_cnt, bit_nx;
    logic [7:0]        byte_sr, byte_sr_nx;
    logic [ADDR_W:0]   byte_cnt, byte_cnt_nx;
    logic              wren_nx;
    logic [ADDR_W-1:0] waddr_nx;
    logic [7:0]        wdata_nx;
    logic              done_nx, abort_nx, align_nx, ovf_nx;
    logic [ADDR_W:0]   len_nx;
    logic              push;

    assign raw_shift = {bus.bit_in, raw_sr[7:1]};
    assign in_frame  = (state == DATA);

    always_comb begin
        state_nx    = state;
        raw_nx      = raw_sr;
        ones_nx     = ones_cnt;
        dly_nx      = dly_cnt;
        dly_sr_nx   = dly_sr;
        bit_nx      = bit_cnt;
        byte_sr_nx  = byte_sr;
        byte_cnt_nx = byte_cnt;
        wren_nx     = 1'b0;
        waddr_nx    = bus.ram_waddr;
        wdata_nx    = bus.ram_wdata;
        done_nx     = 1'b0;
        len_nx      = frame_len;
        abort_nx    = 1'b0;
        align_nx    = 1'b0;
        ovf_nx      = 1'b0;
        push        = 1'b0;

        if (bus.bit_valid) begin
            raw_nx = raw_shift;
            case (state)
                HUNT: begin
                    if (raw_shift == 8'h7E) begin
                        state_nx    = DATA;
                        ones_nx     = 3'd0;
                        dly_nx      = 3'd0;
                        bit_nx      = 3'd0;
                        byte_cnt_nx = '0;
                    end
                end
                DATA: begin
                    if (bus.bit_in) begin
                        if (ones_cnt >= 3'd6) begin
                            abort_nx = 1'b1;
                            state_nx = HUNT;
                        end else begin
                            ones_nx = ones_cnt + 3'd1;
                            push    = 1'b1;
                        end
                    end else if (ones_cnt == 3'd5) begin
                        ones_nx = 3'd0;
                    end else if (ones_cnt == 3'd6) begin
                        // Closing flag: its 0111111 prefix is still in the delay and is dropped.
                        ones_nx     = 3'd0;
                        dly_nx      = 3'd0;
                        bit_nx      = 3'd0;
                        byte_cnt_nx = '0;
                        if (bit_cnt != 3'd0) begin
                            align_nx = 1'b1;
                        end else if (byte_cnt != '0) begin
                            done_nx = 1'b1;
                            len_nx  = byte_cnt;
                        end
                    end else begin
                        ones_nx = 3'd0;
                        push    = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase

            if (push) begin
                dly_sr_nx = {bus.bit_in, dly_sr[6:1]};
                if (dly_cnt == 3'd7) begin
                    byte_sr_nx = {dly_sr[0], byte_sr[7:1]};
                    bit_nx     = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt == MAX_CNT) begin
                            ovf_nx   = 1'b1;
                            state_nx = HUNT;
                        end else begin
                            wren_nx     = 1'b1;
                            waddr_nx    = byte_cnt[ADDR_W-1:0];
                            wdata_nx    = byte_sr_nx;
                            byte_cnt_nx = byte_cnt + 1'b1;
                        end
                    end
                end else begin
                    dly_nx = dly_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || inr) begin
            state         <= HUNT;
            raw_sr        <= '0;
            ones_cnt      <= '0;
            dly_cnt       <= '0;
            dly_sr        <= '0;
            bit_cnt       <= '0;
            byte_sr       <= '0;
            byte_cnt      <= '0;
            bus.ram_wren  <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_wdata <= '0;
            frame_done    <= 1'b0;
            frame_len     <= '0;
            abort_err     <= 1'b0;
            align_err     <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            state         <= state_nx;
            raw_sr        <= raw_nx;
            ones_cnt      <= ones_nx;
            dly_cnt       <= dly_nx;
            dly_sr        <= dly_sr_nx;
            bit_cnt       <= bit_nx;
            byte_sr       <= byte_sr_nx;
            byte_cnt      <= byte_cnt_nx;
            bus.ram_wren  <= wren_nx;
            bus.ram_waddr <= waddr_nx;
            bus.ram_wdata <= wdata_nx;
            frame_done    <= done_nx;
            frame_len     <= len_nx;
            abort_err     <= abort_nx;
            align_err     <= align_nx;
            ovf_err       <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_delete0.sv
// tb/tb_delete0.sv - directed-vector bench for delete0 (default and MAX_BYTES=4 instances)
module tb_delete0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inr = 1'b0;
    always #5 clk = ~clk;

    delete0_if #(.ADDR_W(9)) bus ();
    delete0_if #(.ADDR_W(9)) bus4 ();

    logic       frame_done, abort_err, align_err, ovf_err, in_frame;
    logic [9:0] frame_len;
    logic       frame_done4, abort_err4, align_err4, ovf_err4, in_frame4;
    logic [9:0] frame_len4;

    delete0 #(.ADDR_W(9), .MAX_BYTES(511)) dut (
        .clk(clk), .rst_n(rst_n), .inr(inr), .bus(bus),
        .frame_done(frame_done), .frame_len(frame_len), .abort_err(abort_err),
        .align_err(align_err), .ovf_err(ovf_err), .in_frame(in_frame)
    );

    delete0 #(.ADDR_W(9), .MAX_BYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inr(inr), .bus(bus4),
        .frame_done(frame_done4), .frame_len(frame_len4), .abort_err(abort_err4),
        .align_err(align_err4), .ovf_err(ovf_err4), .in_frame(in_frame4)
    );

    int nvec = 0;
    int nerr = 0;
    bit gap_mode = 1'b0;

    logic [8:0] wa [0:15];
    logic [7:0] wd [0:15];
    logic [9:0] lens [0:15];
    int wn, done_n, abort_n, align_n, ovf_n;
    logic [8:0] wa4 [0:15];
    logic [7:0] wd4 [0:15];
    int wn4, done4_n, ovf4_n;

    always @(negedge clk) begin
        if (bus.ram_wren) begin
            if (wn < 16) begin wa[wn] = bus.ram_waddr; wd[wn] = bus.ram_wdata; end
            wn++;
        end
        if (frame_done) begin
            if (done_n < 16) lens[done_n] = frame_len;
            done_n++;
        end
        if (abort_err) abort_n++;
        if (align_err) align_n++;
        if (ovf_err)   ovf_n++;
        if (bus4.ram_wren) begin
            if (wn4 < 16) begin wa4[wn4] = bus4.ram_waddr; wd4[wn4] = bus4.ram_wdata; end
            wn4++;
        end
        if (frame_done4) done4_n++;
        if (ovf_err4)    ovf4_n++;
    end

    task automatic clear_log();
        wn = 0; done_n = 0; abort_n = 0; align_n = 0; ovf_n = 0;
        wn4 = 0; done4_n = 0; ovf4_n = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.bit_valid = 1'b0; bus4.bit_valid = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        if (gap_mode) idle($urandom_range(0, 2));
        @(negedge clk);
        bus.bit_in = b;  bus.bit_valid = 1'b1;
        bus4.bit_in = b; bus4.bit_valid = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.bit_valid = 1'b0; bus4.bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle(3);
        nvec++; if ({bus.ram_wren, frame_done, abort_err, align_err, ovf_err, in_frame} !== 6'b0) begin
            nerr++; $display("FAIL reset_pulses got %b want 000000", {bus.ram_wren, frame_done, abort_err, align_err, ovf_err, in_frame}); end
        nvec++; if (bus.ram_waddr !== 9'd0 || bus.ram_wdata !== 8'd0) begin
            nerr++; $display("FAIL reset_wport got addr=%0d data=%h want 0/00", bus.ram_waddr, bus.ram_wdata); end
        nvec++; if (frame_len !== 10'd0) begin
            nerr++; $display("FAIL reset_len got %0d want 0", frame_len); end
    endtask

    task automatic check_two_byte_frame(input string tag);
        nvec++; if (wn !== 2) begin nerr++; $display("FAIL %s_wcount got %0d want 2", tag, wn); end
        nvec++; if (wa[0] !== 9'd0 || wd[0] !== 8'h3C) begin
            nerr++; $display("FAIL %s_w0 got %0d/%h want 0/3c", tag, wa[0], wd[0]); end
        nvec++; if (wa[1] !== 9'd1 || wd[1] !== 8'hA5) begin
            nerr++; $display("FAIL %s_w1 got %0d/%h want 1/a5", tag, wa[1], wd[1]); end
        nvec++; if (done_n !== 1 || lens[0] !== 10'd2) begin
            nerr++; $display("FAIL %s_done got n=%0d len=%0d want 1/2", tag, done_n, lens[0]); end
        nvec++; if (abort_n + align_n + ovf_n !== 0) begin
            nerr++; $display("FAIL %s_errs got %0d want 0", tag, abort_n + align_n + ovf_n); end
    endtask

    task automatic test_basic();
        clear_log();
        send_byte(8'h7E); send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h7E);
        idle(4);
        check_two_byte_frame("basic");
        nvec++; if (bus.ram_waddr !== 9'd1 || bus.ram_wdata !== 8'hA5) begin
            nerr++; $display("FAIL basic_hold got %0d/%h want 1/a5", bus.ram_waddr, bus.ram_wdata); end
        nvec++; if (in_frame !== 1'b1) begin nerr++; $display("FAIL basic_inframe got %b want 1", in_frame); end
    endtask

    task automatic test_stuffed();
        logic [8:0] raw;
        raw = 9'b111011111;
        clear_log();
        send_byte(8'h7E);
        for (int i = 0; i < 9; i++) send_bit(raw[i]);
        send_byte(8'h7E);
        idle(4);
        nvec++; if (wn !== 1 || wa[0] !== 9'd0 || wd[0] !== 8'hFF) begin
            nerr++; $display("FAIL stuff_write got n=%0d %0d/%h want 1 0/ff", wn, wa[0], wd[0]); end
        nvec++; if (done_n !== 1 || lens[0] !== 10'd1 || align_n !== 0) begin
            nerr++; $display("FAIL stuff_done got n=%0d len=%0d align=%0d want 1/1/0", done_n, lens[0], align_n); end
    endtask

    task automatic test_abort();
        clear_log();
        send_byte(8'h7E); send_byte(8'h01);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        idle(3);
        nvec++; if (abort_n !== 1 || in_frame !== 1'b0) begin
            nerr++; $display("FAIL abort_pulse got n=%0d inframe=%b want 1/0", abort_n, in_frame); end
        nvec++; if (done_n !== 0 || wn !== 0) begin
            nerr++; $display("FAIL abort_nodata got done=%0d writes=%0d want 0/0", done_n, wn); end
        clear_log();
        send_byte(8'h7E); send_byte(8'h55); send_byte(8'h7E);
        idle(4);
        nvec++; if (wn !== 1 || wa[0] !== 9'd0 || wd[0] !== 8'h55 || done_n !== 1 || lens[0] !== 10'd1) begin
            nerr++; $display("FAIL abort_recover got n=%0d %0d/%h done=%0d want 1 0/55 1", wn, wa[0], wd[0], done_n); end
    endtask

    task automatic test_align();
        clear_log();
        send_byte(8'h7E); send_byte(8'hA3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(8'h7E);
        idle(4);
        nvec++; if (wn !== 1 || wd[0] !== 8'hA3) begin
            nerr++; $display("FAIL align_write got n=%0d %h want 1/a3", wn, wd[0]); end
        nvec++; if (align_n !== 1 || done_n !== 0) begin
            nerr++; $display("FAIL align_pulse got align=%0d done=%0d want 1/0", align_n, done_n); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_byte(8'h7E); send_byte(8'h7E); send_byte(8'h7E);
        send_byte(8'h55); send_byte(8'h7E); send_byte(8'hAA); send_byte(8'h7E);
        idle(4);
        nvec++; if (wn !== 2 || wa[0] !== 9'd0 || wd[0] !== 8'h55 || wa[1] !== 9'd0 || wd[1] !== 8'hAA) begin
            nerr++; $display("FAIL shared_writes got n=%0d %0d/%h %0d/%h want 2 0/55 0/aa", wn, wa[0], wd[0], wa[1], wd[1]); end
        nvec++; if (done_n !== 2 || lens[0] !== 10'd1 || lens[1] !== 10'd1) begin
            nerr++; $display("FAIL shared_done got n=%0d want 2 frames of len 1", done_n); end
        nvec++; if (abort_n + align_n + ovf_n !== 0) begin
            nerr++; $display("FAIL shared_errs got %0d want 0", abort_n + align_n + ovf_n); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        clear_log();
        send_byte(8'h7E);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        send_byte(8'h00);
        idle(4);
        nvec++; if (wn4 !== 4 || wa4[3] !== 9'd3 || wd4[0] !== 8'h11 || wd4[3] !== 8'h44) begin
            nerr++; $display("FAIL ovf_writes got n=%0d a3=%0d d0=%h d3=%h want 4 3 11 44", wn4, wa4[3], wd4[0], wd4[3]); end
        nvec++; if (ovf4_n !== 1 || in_frame4 !== 1'b0 || done4_n !== 0) begin
            nerr++; $display("FAIL ovf_pulse got ovf=%0d inframe=%b done=%0d want 1/0/0", ovf4_n, in_frame4, done4_n); end
        nvec++; if (ovf_n !== 0 || wn !== 5) begin
            nerr++; $display("FAIL ovf_bigdut got ovf=%0d writes=%0d want 0/5", ovf_n, wn); end
        send_byte(8'h7E);
        idle(4);
    endtask

    task automatic test_gaps();
        clear_log();
        gap_mode = 1'b1;
        send_byte(8'h7E); send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h7E);
        gap_mode = 1'b0;
        idle(4);
        check_two_byte_frame("gaps");
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h7E); send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        pulse_reset();
        clear_log();
        idle(10);
        nvec++; if (done_n + abort_n + align_n + ovf_n !== 0 || in_frame !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_quiet got pulses=%0d inframe=%b want 0/0", done_n + abort_n + align_n + ovf_n, in_frame); end
        send_byte(8'h7E); send_byte(8'h3C); send_byte(8'h7E);
        idle(4);
        nvec++; if (wn !== 1 || wa[0] !== 9'd0 || wd[0] !== 8'h3C || done_n !== 1 || lens[0] !== 10'd1) begin
            nerr++; $display("FAIL rst_mid_new got n=%0d %0d/%h done=%0d want 1 0/3c 1", wn, wa[0], wd[0], done_n); end
        send_byte(8'hA5); send_bit(1'b0);
        @(negedge clk); inr = 1'b1; bus.bit_valid = 1'b0; bus4.bit_valid = 1'b0;
        @(negedge clk); inr = 1'b0;
        nvec++; if (in_frame !== 1'b0 || frame_len !== 10'd0 || bus.ram_waddr !== 9'd0) begin
            nerr++; $display("FAIL inr_clear got inframe=%b len=%0d addr=%0d want 0/0/0", in_frame, frame_len, bus.ram_waddr); end
    endtask

    initial begin
        bus.bit_in = 1'b0;  bus.bit_valid = 1'b0;
        bus4.bit_in = 1'b0; bus4.bit_valid = 1'b0;
        clear_log();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_stuffed();
        test_abort();
        test_align();
        test_back_to_back();
        test_overflow();
        test_gaps();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
